// File: rtl/uart_transmitter_serializer.sv
// uart_transmitter_serializer: one-bit-per-clk UART TX frame serializer (start, LSB-first data, optional parity, stop)
// Ports: clk_i, reset_i (sync, active-high), parallel_data_valid_i, parallel_data_i[DATA_WIDTH],
//        parity_enable_i, parity_type_i (0 even, 1 odd) -> serial_data_o (idle high), busy_o
module uart_transmitter_serializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  parallel_data_valid_i,
  input  logic [DATA_WIDTH-1:0] parallel_data_i,
  input  logic                  parity_enable_i,
  input  logic                  parity_type_i,
  output logic                  serial_data_o,
  output logic                  busy_o
);
  localparam int CW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  par_en_q, par_en_d, par_bit_q, par_bit_d;
  logic                  serial_q, serial_d, busy_q, busy_d;
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    case (state_q)
      IDLE: if (parallel_data_valid_i) begin
        state_d   = START;
        shift_d   = parallel_data_i;
        par_en_d  = parity_enable_i;
        par_bit_d = (^parallel_data_i) ^ parity_type_i;
      end
      START:   begin state_d = DATA; cnt_d = '0; end
      DATA:    if (cnt_q == CW'(DATA_WIDTH - 1)) state_d = par_en_q ? PARITY : STOP;
               else cnt_d = cnt_q + CW'(1);
      PARITY:  state_d = STOP;
      STOP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Outputs are registered, so the line value is chosen from the state being entered;
    // shift_q[0] already holds the next data bit, then the register advances.
    if (state_d == DATA) shift_d = shift_q >> 1;
    serial_d = state_d == START ? 1'b0 : state_d == DATA ? shift_q[0] : state_d == PARITY ? par_bit_q : 1'b1;
    busy_d   = state_d != IDLE;
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      serial_q  <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      serial_q  <= serial_d;
      busy_q    <= busy_d;
    end
  end
  assign serial_data_o = serial_q;
  assign busy_o        = busy_q;
endmodule
